mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single shared instruction/data memory port between the icache (loads only) and the dcache (loads and stores).
- Forwards the winning request to memory combinationally and returns the accept tag to the winner only.
- Records which requester owns each outstanding load tag and steers the tagged data returned later back to that owner.
- Sits between the two caches and the mem model, replacing their direct connections.

Parameters:
- XLEN, 32, address width.
- TAG_W, 4, memory tag width; tag 0 means "no tag / rejected".
- STARVE_LIMIT, 4, consecutive denied icache request cycles after which the icache gets priority for one grant.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- Imem_command  in  2  icache request; 0 NONE, 1 LOAD; 2/3 are treated as NONE.
- Imem_addr  in  XLEN  icache address.
- Dmem_command  in  2  dcache request; 0 NONE, 1 LOAD, 2 STORE, 3 NONE.
- Dmem_addr  in  XLEN  dcache address.
- Dmem_data  in  64  dcache store data.
- mem2proc_response  in  TAG_W  memory accept tag for this cycle's request; 0 means rejected.
- mem2proc_data  in  64  returned load data.
- mem2proc_tag  in  TAG_W  tag of returned data; 0 means none.
- proc2mem_command  out  2  forwarded command.
- proc2mem_addr  out  XLEN  forwarded address.
- proc2mem_data  out  64  forwarded store data.
- Imem2proc_response  out  TAG_W  accept tag to icache.
- Imem2proc_data  out  64  data to icache.
- Imem2proc_tag  out  TAG_W  returned tag to icache.
- Dmem2proc_response  out  TAG_W  accept tag to dcache.
- Dmem2proc_data  out  64  data to dcache.
- Dmem2proc_tag  out  TAG_W  returned tag to dcache.
- d_granted  out  1  this cycle's grant went to the dcache.
- tag_error  out  1  registered one-cycle pulse: returned tag had no valid owner entry.

Behaviour:
- Reset: owner table entries (2^TAG_W − 1 entries, each {valid, owner}) all cleared. starve_cnt = 0. tag_error = 0.
- While reset_n = 0 the combinational outputs follow their normal rules, but with the cleared table they carry no live grants or returns.
- Request validity: i_req = (Imem_command == LOAD); d_req = (Dmem_command == LOAD || Dmem_command == STORE).
- Grant (combinational, same cycle):
  - If only one requester is valid, it wins.
  - If both are valid, the dcache wins unless starve_cnt >= STARVE_LIMIT, in which case the icache wins.
  - If neither is valid, proc2mem_command = NONE, addr = 0, data = 0.
- Forwarding: the winner's command and address drive the memory port. proc2mem_data = Dmem_data when the dcache wins, else 0.
- Accept tag: mem2proc_response is routed to the winner's *mem2proc_response output. The loser and any idle requester see 0 and must retry next cycle.
- starve_cnt (registered), with the first matching rule applied:
  - i_req and not granted: increment, saturating at STARVE_LIMIT.
  - icache granted and the response is nonzero: reset to 0.
  - icache granted but rejected (response 0): hold.
  - no i_req: reset to 0.
- Owner table write (posedge): on an accepted LOAD (response != 0), set entry[response] = {valid = 1, owner = I/D}. Accepted STOREs are not recorded, since no data returns for them.
- Return path (combinational):
  - If mem2proc_tag != 0 and entry[mem2proc_tag].valid, drive data and tag to the owner. The other cache sees tag 0 and data 0.
  - The entry is cleared at posedge.
  - If the tag is nonzero but the entry is invalid, drop the return (both caches see tag 0) and pulse tag_error the next cycle.
- Simultaneous return and issue with the same tag: the return lookup uses the old entry; the new issue's write takes precedence over the clear.
- Asynchronous reset mid-operation clears the table. Data returned later for pre-reset tags is dropped and flagged via tag_error.

Test Plan:
- Only the icache requests LOAD 0x100 and memory responds 3 → Imem2proc_response = 3, Dmem2proc_response = 0. Later, data 0xDEAD with tag 3 → Imem2proc_tag = 3, Imem2proc_data = 0xDEAD, and the dcache sees tag 0.
- Both request (I LOAD 0x200, D LOAD 0x40), memory responds 5 → d_granted = 1, Dmem2proc_response = 5, Imem2proc_response = 0. A return on tag 5 goes to the dcache.
- Dcache requests continuously and the icache is held pending with STARVE_LIMIT = 4 → the icache is granted on its 5th request cycle. starve_cnt returns to 0 after acceptance, and the dcache is denied that cycle.
- Dcache STORE 0x80, data 0x1234, memory responds 7 → forwarded data = 0x1234, no table entry is made. A later return on tag 7 → dropped and tag_error pulses.
- Tag 2 returns to the icache in the same cycle a new dcache LOAD is accepted with tag 2 → the icache gets the data, entry 2 becomes owner D, and a subsequent tag-2 return goes to the dcache.
- reset_n asserted with tags 1 and 4 outstanding, then released; tag 4 returns → both caches see tag 0 and tag_error = 1 for one cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side and memory-side signals around the memory arbiter.
// The caches and memory model hold the master side; the arbiter holds the slave side.
interface mem_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic [1:0]       Imem_command;
    logic [XLEN-1:0]  Imem_addr;
    logic [1:0]       Dmem_command;
    logic [XLEN-1:0]  Dmem_addr;
    logic [63:0]      Dmem_data;
    logic [TAG_W-1:0] mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [TAG_W-1:0] mem2proc_tag;

    logic [1:0]       proc2mem_command;
    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [TAG_W-1:0] Imem2proc_response;
    logic [63:0]      Imem2proc_data;
    logic [TAG_W-1:0] Imem2proc_tag;
    logic [TAG_W-1:0] Dmem2proc_response;
    logic [63:0]      Dmem2proc_data;
    logic [TAG_W-1:0] Dmem2proc_tag;
    logic             d_granted;
    logic             tag_error;

    modport master (
        output Imem_command, Imem_addr,
        output Dmem_command, Dmem_addr, Dmem_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        input  d_granted, tag_error
    );

    modport slave (
        input  Imem_command, Imem_addr,
        input  Dmem_command, Dmem_addr, Dmem_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
        output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
        output d_granted, tag_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache and dcache, with an anti-starvation
// counter for the icache and a tag owner table that steers returns.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int NENT  = 1 << TAG_W;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             i_req;
    logic             d_req;
    logic             starved;
    logic             i_win;
    logic             d_win;
    logic [1:0]       fwd_cmd;
    logic             resp_nz;
    logic             accept_load;
    logic             ret_nz;
    logic             ret_hit;
    logic             ret_own_d;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [NENT-1:0]  valid_q, valid_d;
    // owner bit set means the dcache issued that tag
    logic [NENT-1:0]  owner_q, owner_d;
    logic             tag_error_q, tag_error_d;

    always_comb begin
        i_req   = (bus.Imem_command == CMD_LOAD);
        d_req   = (bus.Dmem_command == CMD_LOAD)
               || (bus.Dmem_command == CMD_STORE);
        starved = (starve_cnt_q >= LIMIT);
        i_win   = i_req && (!d_req || starved);
        d_win   = d_req && !i_win;
    end

    always_comb begin
        fwd_cmd = CMD_NONE;
        bus.proc2mem_addr = '0;
        bus.proc2mem_data = '0;
        unique case (1'b1)
            d_win: begin
                fwd_cmd = bus.Dmem_command;
                bus.proc2mem_addr = bus.Dmem_addr;
                bus.proc2mem_data = bus.Dmem_data;
            end
            i_win: begin
                fwd_cmd = CMD_LOAD;
                bus.proc2mem_addr = bus.Imem_addr;
            end
            default: ;
        endcase
        bus.proc2mem_command = fwd_cmd;
        bus.d_granted = d_win;
    end

    always_comb begin
        resp_nz     = (bus.mem2proc_response != '0);
        accept_load = resp_nz && (fwd_cmd == CMD_LOAD);
        bus.Imem2proc_response = i_win ? bus.mem2proc_response : '0;
        bus.Dmem2proc_response = d_win ? bus.mem2proc_response : '0;
    end

    always_comb begin
        ret_nz    = (bus.mem2proc_tag != '0);
        ret_hit   = ret_nz && valid_q[bus.mem2proc_tag];
        ret_own_d = owner_q[bus.mem2proc_tag];
        bus.Imem2proc_tag  = '0;
        bus.Imem2proc_data = '0;
        bus.Dmem2proc_tag  = '0;
        bus.Dmem2proc_data = '0;
        if (ret_hit && ret_own_d) begin
            bus.Dmem2proc_tag  = bus.mem2proc_tag;
            bus.Dmem2proc_data = bus.mem2proc_data;
        end else if (ret_hit) begin
            bus.Imem2proc_tag  = bus.mem2proc_tag;
            bus.Imem2proc_data = bus.mem2proc_data;
        end
        bus.tag_error = tag_error_q;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_req && !i_win) begin
            if (starve_cnt_q != LIMIT) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (i_win && resp_nz) begin
            starve_cnt_d = '0;
        end else if (!i_win) begin
            starve_cnt_d = '0;
        end
    end

    // a new issue on the returning tag overrides that tag's clear
    always_comb begin
        valid_d     = valid_q;
        owner_d     = owner_q;
        tag_error_d = ret_nz && !ret_hit;
        if (ret_hit) begin
            valid_d[bus.mem2proc_tag] = 1'b0;
        end
        if (accept_load) begin
            valid_d[bus.mem2proc_response] = 1'b1;
            owner_d[bus.mem2proc_response] = d_win;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
            valid_q      <= '0;
            owner_q      <= '0;
            tag_error_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            tag_error_q  <= tag_error_d;
        end
    end
endmodule
